gpu_instruction_fifo: RTL



---
 rtl/gpu_instruction_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gpu_instruction_fifo.sv
// gpu_instruction_fifo
// ---------------------------------------------------------------------------
// First-word-fall-through FIFO for packed GPU drawing instructions. Each entry
// holds {opcode, x1, y1, x2, y2, rad, oct, r, g, b}. Storage is a circular
// buffer indexed by write/read pointers, with a separate entry count.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   push_i + fields     : write the instruction fields this cycle
//   pop_i               : consumer has taken the head entry
//   flush_i             : synchronous clear of all entries and overflow flag
//   *_o fields          : head entry fields (all zero while valid_o=0)
//   valid_o             : head entry present (count != 0)
//   full_o              : FIFO holds DEPTH entries
//   count_o             : number of stored entries
//   overflow_o          : sticky, set when a push was dropped at full
//
// Handshake: a push is taken on a rising edge when push_i=1 and the FIFO is
// not full, or is full but pop_i=1 frees the head slot in the same edge. A pop
// is taken on a rising edge when pop_i=1 and valid_o=1; pop_i on an empty FIFO
// is ignored. flush_i overrides both.
// ---------------------------------------------------------------------------

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [3:0]                 opcode_i,
  input  logic [`WIDTH_BITS-1:0]     x1_i,
  input  logic [`HEIGHT_BITS-1:0]    y1_i,
  input  logic [`WIDTH_BITS-1:0]     x2_i,
  input  logic [`HEIGHT_BITS-1:0]    y2_i,
  input  logic [`WIDTH_BITS-1:0]     rad_i,
  input  logic [2:0]                 oct_i,
  input  logic [`CHANNEL_BITS-1:0]   r_i,
  input  logic [`CHANNEL_BITS-1:0]   g_i,
  input  logic [`CHANNEL_BITS-1:0]   b_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [3:0]                 opcode_o,
  output logic [`WIDTH_BITS-1:0]     x1_o,
  output logic [`HEIGHT_BITS-1:0]    y1_o,
  output logic [`WIDTH_BITS-1:0]     x2_o,
  output logic [`HEIGHT_BITS-1:0]    y2_o,
  output logic [`WIDTH_BITS-1:0]     rad_o,
  output logic [2:0]                 oct_o,
  output logic [`CHANNEL_BITS-1:0]   r_o,
  output logic [`CHANNEL_BITS-1:0]   g_o,
  output logic [`CHANNEL_BITS-1:0]   b_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + 3 * `WIDTH_BITS + 2 * `HEIGHT_BITS + 3 + 3 * `CHANNEL_BITS;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          valid;
  logic          full;
  logic          push_acc;
  logic          pop_acc;
  logic          push_drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // At full a concurrent pop frees the head slot, so the push can reuse it.
  assign push_acc  = push_i & (~full | pop_i);
  assign pop_acc   = pop_i & valid;
  assign push_drop = push_i & full & ~pop_i;

  assign wr_entry = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
      else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
      if (push_drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; its contents are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!flush_i && push_acc) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = valid ? mem_q[rd_ptr_q] : '0;

  assign {opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, oct_o, r_o, g_o, b_o} = head;

  assign valid_o    = valid;
  assign full_o     = full;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
